// File: rtl/chorus_chirp_ctrl_if.sv
// chorus_chirp_ctrl_if: control, parameter-load and status bundle between the chirp
// reload sequencer (slave side) and its host/core environment (master side).
interface chorus_chirp_ctrl_if #(
    parameter int G_DIN_WIDTH = 24
);
    logic                   ctrl_enable;
    logic [G_DIN_WIDTH-1:0] cfg_depth;
    logic [G_DIN_WIDTH-1:0] cfg_deriv;
    logic [G_DIN_WIDTH-1:0] cfg_offset;
    logic                   cfg_update;
    logic                   cfg_busy;
    logic                   cfg_done;
    logic                   core_enable;
    logic [G_DIN_WIDTH-1:0] core_depth;
    logic [G_DIN_WIDTH-1:0] core_deriv;
    logic [G_DIN_WIDTH-1:0] core_offset;
    logic                   core_din_valid;
    logic                   core_din_ready;
    logic                   core_dout_valid;
    logic                   core_dout_ready;
    logic                   status_running;
    logic [15:0]            status_load_cnt;
    logic                   status_err;

    modport slave (
        input  ctrl_enable, cfg_depth, cfg_deriv, cfg_offset, cfg_update,
               core_din_ready, core_dout_valid, core_dout_ready,
        output cfg_busy, cfg_done, core_enable, core_depth, core_deriv, core_offset,
               core_din_valid, status_running, status_load_cnt, status_err
    );

    modport master (
        output ctrl_enable, cfg_depth, cfg_deriv, cfg_offset, cfg_update,
               core_din_ready, core_dout_valid, core_dout_ready,
        input  cfg_busy, cfg_done, core_enable, core_depth, core_deriv, core_offset,
               core_din_valid, status_running, status_load_cnt, status_err
    );
endinterface

// File: rtl/chorus_chirp_ctrl.sv
// chorus_chirp_ctrl: flush / load / prime / run sequencer that reloads chirp core parameters.
// Define CHORUS_CHIRP_CTRL_TIMEOUT_EN to add the LOAD-state watchdog (sticky status_err, retry).
module chorus_chirp_ctrl #(
    parameter int G_DIN_WIDTH      = 24,
    parameter int G_FLUSH_CYCLES   = 4,
    parameter int G_TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    chorus_chirp_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FLUSH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_PRIME = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;

    localparam logic [7:0] FLUSH_LAST = 8'(G_FLUSH_CYCLES - 1);

    if ((G_FLUSH_CYCLES < 1) || (G_FLUSH_CYCLES > 255) ||
        (G_TIMEOUT_CYCLES < 2) || (G_TIMEOUT_CYCLES > 65535)) begin : g_param_check
        $error("chorus_chirp_ctrl: parameter out of range");
    end

    logic [1:0]             r_rst_sync;
    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [7:0]             r_flush_cnt;
    logic                   r_pend;
    logic [G_DIN_WIDTH-1:0] r_pend_depth;
    logic [G_DIN_WIDTH-1:0] r_pend_deriv;
    logic [G_DIN_WIDTH-1:0] r_pend_offset;
    logic [G_DIN_WIDTH-1:0] r_core_depth;
    logic [G_DIN_WIDTH-1:0] r_core_deriv;
    logic [G_DIN_WIDTH-1:0] r_core_offset;
    logic                   r_core_enable;
    logic                   r_din_valid;
    logic                   r_cfg_done;
    logic                   r_running;
    logic                   r_busy;
    logic                   r_err;
    logic [15:0]            r_load_cnt;
    logic                   w_handshake;
    logic                   w_timeout;
    logic                   w_flush_entry;
    logic                   w_pend_nxt;

    // A handshake only counts when the sequence is not being torn down by ctrl_enable.
    assign w_handshake   = bus.ctrl_enable && (r_state == ST_LOAD) && r_din_valid && bus.core_din_ready;
    assign w_flush_entry = (w_state_nxt == ST_FLUSH) && (r_state != ST_FLUSH);
    assign w_pend_nxt    = bus.cfg_update || (r_pend && !w_flush_entry);

`ifdef CHORUS_CHIRP_CTRL_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(G_TIMEOUT_CYCLES - 1);

    logic [15:0] r_wd_cnt;

    assign w_timeout = bus.ctrl_enable && (r_state == ST_LOAD) && !w_handshake &&
                       (r_wd_cnt == TIMEOUT_LAST);

    // Watchdog: cycles spent waiting in LOAD, restarted on every LOAD entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt <= 16'd0;
        end else if ((r_state == ST_LOAD) && (w_state_nxt == ST_LOAD)) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end else begin
            r_wd_cnt <= 16'd0;
        end
    end

    // Sticky watchdog error; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end
`else
    assign w_timeout = 1'b0;

    // Without the watchdog the error flag is permanently clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
        end
    end
`endif

    // Two-flop release synchroniser; the FSM may only leave IDLE once it is through.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Next-state logic; dropping ctrl_enable overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.ctrl_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_rst_sync[1]) begin
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == 8'd0) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt = ST_FLUSH;
                    end
                end
                ST_LOAD: begin
                    if (w_handshake) begin
                        w_state_nxt = ST_PRIME;
                    end else if (w_timeout) begin
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_PRIME: begin
                    if (bus.core_dout_valid && bus.core_dout_ready) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_PRIME;
                    end
                end
                ST_RUN: begin
                    if (r_pend) begin
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register and flush down-counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_flush_entry) begin
                r_flush_cnt <= FLUSH_LAST;
            end else if ((r_state == ST_FLUSH) && (r_flush_cnt != 8'd0)) begin
                r_flush_cnt <= r_flush_cnt - 8'd1;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    // Pending capture and core parameter hand-over; a capture on the FLUSH-entry edge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend        <= 1'b0;
            r_pend_depth  <= '0;
            r_pend_deriv  <= '0;
            r_pend_offset <= '0;
            r_core_depth  <= '0;
            r_core_deriv  <= '0;
            r_core_offset <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            if (bus.cfg_update) begin
                r_pend_depth  <= bus.cfg_depth;
                r_pend_deriv  <= bus.cfg_deriv;
                r_pend_offset <= bus.cfg_offset;
            end else begin
                r_pend_depth  <= r_pend_depth;
                r_pend_deriv  <= r_pend_deriv;
                r_pend_offset <= r_pend_offset;
            end
            if (w_flush_entry && r_pend) begin
                r_core_depth  <= r_pend_depth;
                r_core_deriv  <= r_pend_deriv;
                r_core_offset <= r_pend_offset;
            end else begin
                r_core_depth  <= r_core_depth;
                r_core_deriv  <= r_core_deriv;
                r_core_offset <= r_core_offset;
            end
        end
    end

    // Registered control/status outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_core_enable <= 1'b0;
            r_din_valid   <= 1'b0;
            r_cfg_done    <= 1'b0;
            r_running     <= 1'b0;
            r_busy        <= 1'b0;
            r_load_cnt    <= 16'd0;
        end else begin
            r_core_enable <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_PRIME) ||
                             (w_state_nxt == ST_RUN);
            r_din_valid   <= (w_state_nxt == ST_LOAD);
            r_cfg_done    <= (w_state_nxt == ST_RUN) && (r_state == ST_PRIME);
            r_running     <= (w_state_nxt == ST_RUN);
            r_busy        <= w_pend_nxt || ((w_state_nxt != ST_IDLE) && (w_state_nxt != ST_RUN));
            if (w_handshake) begin
                r_load_cnt <= r_load_cnt + 16'd1;
            end else begin
                r_load_cnt <= r_load_cnt;
            end
        end
    end

    assign bus.core_enable     = r_core_enable;
    assign bus.core_din_valid  = r_din_valid;
    assign bus.core_depth      = r_core_depth;
    assign bus.core_deriv      = r_core_deriv;
    assign bus.core_offset     = r_core_offset;
    assign bus.cfg_done        = r_cfg_done;
    assign bus.cfg_busy        = r_busy;
    assign bus.status_running  = r_running;
    assign bus.status_load_cnt = r_load_cnt;
    assign bus.status_err      = r_err;
endmodule

// File: tb/tb_chorus_chirp_ctrl.sv
// tb_chorus_chirp_ctrl: scoreboard bench for chorus_chirp_ctrl; each expected reload is queued
// when its stimulus is driven and checked when the DUT pulses cfg_done.
module tb_chorus_chirp_ctrl;
    typedef struct packed {
        logic [23:0] d;
        logic [23:0] r;
        logic [23:0] o;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [23:0] A_DEPTH = 24'hAAAAAA;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_done  = 0;
    bit   seen_a  = 1'b0;
    exp_t sb_q[$];
    bit   win_ce [0:63];
    bit   win_dv [0:63];
    bit   win_dn [0:63];
    bit   win_bs [0:63];

    chorus_chirp_ctrl_if #(.G_DIN_WIDTH(24)) bus ();

    chorus_chirp_ctrl #(
        .G_DIN_WIDTH     (24),
        .G_FLUSH_CYCLES  (4),
        .G_TIMEOUT_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [23:0] d, input logic [23:0] r, input logic [23:0] o,
                            input logic [15:0] cnt);
        exp_t e;
        e.d = d; e.r = r; e.o = o; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every cfg_done pulse must match the oldest queued reload.
    always @(negedge clk) begin
        exp_t e;
        if (bus.core_depth == A_DEPTH) seen_a = 1'b1;
        if (bus.cfg_done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_depth",  bus.core_depth,      e.d);
                check_val("sb_deriv",  bus.core_deriv,      e.r);
                check_val("sb_offset", bus.core_offset,     e.o);
                check_val("sb_cnt",    bus.status_load_cnt, e.cnt);
            end
        end
    end

    task automatic drive_update(input logic [23:0] d, input logic [23:0] r, input logic [23:0] o);
        bus.cfg_depth  = d;
        bus.cfg_deriv  = r;
        bus.cfg_offset = o;
        bus.cfg_update = 1'b1;
        @(posedge clk); #1;
        bus.cfg_update = 1'b0;
    endtask

    task automatic sample_window(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            win_ce[i] = bus.core_enable;
            win_dv[i] = bus.core_din_valid;
            win_dn[i] = bus.cfg_done;
            win_bs[i] = bus.cfg_busy;
        end
    endtask

    task automatic window_stats(input int n, output int first_flush, output int n_flush,
                                output int n_load, output int last_load, output int first_done);
        first_flush = -1; n_flush = 0; n_load = 0; last_load = -1; first_done = -1;
        for (int i = 0; i < n; i++) begin
            if (win_bs[i] && !win_ce[i]) begin
                n_flush++;
                if (first_flush < 0) first_flush = i;
            end
            if (win_dv[i]) begin
                n_load++;
                last_load = i;
            end
            if (win_dn[i] && (first_done < 0)) first_done = i;
        end
    endtask

    task automatic wait_dones(input int target, input string tag);
        int k;
        k = 0;
        while ((n_done < target) && (k < 200)) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, n_done, target);
    endtask

    task automatic wait_load(input string tag);
        int  k;
        bit  found;
        k = 0;
        found = 1'b0;
        while (!found && (k < 50)) begin
            @(negedge clk);
            found = (bus.core_din_valid === 1'b1);
            k++;
        end
        check_val(tag, found, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int ff, nf, nl, ll, fd, first_err, n_dv;
        bit reflush;

        bus.ctrl_enable     = 1'b0;
        bus.cfg_depth       = 24'h000000;
        bus.cfg_deriv       = 24'h000000;
        bus.cfg_offset      = 24'h000000;
        bus.cfg_update      = 1'b0;
        bus.core_din_ready  = 1'b1;
        bus.core_dout_valid = 1'b1;
        bus.core_dout_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_core_enable", bus.core_enable,     1'b0);
        check_val("rst_din_valid",   bus.core_din_valid,  1'b0);
        check_val("rst_cfg_done",    bus.cfg_done,        1'b0);
        check_val("rst_busy",        bus.cfg_busy,        1'b0);
        check_val("rst_running",     bus.status_running,  1'b0);
        check_val("rst_load_cnt",    bus.status_load_cnt, 16'd0);
        check_val("rst_err",         bus.status_err,      1'b0);
        check_val("rst_core_params", {bus.core_depth, bus.core_deriv, bus.core_offset}, 72'd0);

        // Bring-up: flush 4, load 1, prime 1, then RUN
        push_exp(24'h000000, 24'h000000, 24'h000000, 16'd1);
        bus.ctrl_enable = 1'b1;
        reset_n = 1'b1;
        sample_window(16);
        window_stats(16, ff, nf, nl, ll, fd);
        check_val("boot_first_flush", ff, 2);
        check_val("boot_flush_len",   nf, 4);
        check_val("boot_load_len",    nl, 1);
        check_val("boot_done_after",  fd - ll, 2);
        check_val("boot_running",     bus.status_running, 1'b1);

        // Update in RUN: core_enable low two cycles later for 4 cycles
        push_exp(24'h400000, 24'h000100, 24'h001000, 16'd2);
        drive_update(24'h400000, 24'h000100, 24'h001000);
        sample_window(16);
        window_stats(16, ff, nf, nl, ll, fd);
        check_val("upd_first_flush", ff, 1);
        check_val("upd_flush_len",   nf, 4);
        check_val("upd_load_len",    nl, 1);
        check_val("upd_done_after",  fd - ll, 2);

        // Two updates during FLUSH: in-flight reload, then exactly one more with B
        push_exp(24'h123456, 24'h00ABCD, 24'h0F0F0F, 16'd3);
        drive_update(24'h123456, 24'h00ABCD, 24'h0F0F0F);
        begin
            int k;
            k = 0;
            while ((bus.core_enable !== 1'b0) && (k < 20)) begin
                @(negedge clk);
                k++;
            end
            check_val("p_reached_flush", bus.core_enable, 1'b0);
        end
        bus.cfg_depth  = A_DEPTH;
        bus.cfg_deriv  = 24'h111111;
        bus.cfg_offset = 24'h222222;
        bus.cfg_update = 1'b1;
        @(posedge clk); #1;
        bus.cfg_depth  = 24'h5B5B5B;
        bus.cfg_deriv  = 24'h333333;
        bus.cfg_offset = 24'h444444;
        @(posedge clk); #1;
        bus.cfg_update = 1'b0;
        push_exp(24'h5B5B5B, 24'h333333, 24'h444444, 16'd4);
        wait_dones(3, "done_in_flight");
        wait_dones(4, "done_b_reload");
        repeat (30) @(negedge clk);
        check_val("no_extra_reload", n_done, 4);
        check_val("ab_load_cnt",     bus.status_load_cnt, 16'd4);
        check_val("ab_idle_busy",    bus.cfg_busy, 1'b0);
        check_val("a_never_applied", seen_a, 1'b0);

        // LOAD stall with core_din_ready low: watchdog behaviour depends on build
        bus.core_din_ready = 1'b0;
        drive_update(24'h0C0FFE, 24'h000777, 24'h00BEEF);
        wait_load("q_reached_load");
        first_err = -1; n_dv = 1; reflush = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.core_din_valid) n_dv++;
            if (!bus.core_enable) reflush = 1'b1;
            if (bus.status_err && (first_err < 0)) first_err = i;
        end
`ifdef CHORUS_CHIRP_CTRL_TIMEOUT_EN
        check_val("wd_err_cycle", first_err, 16);
        check_val("wd_reflush",   reflush,   1'b1);
`else
        check_val("nowd_err",     first_err, -1);
        check_val("nowd_load_len", n_dv,     41);
        check_val("nowd_reflush", reflush,   1'b0);
`endif
        push_exp(24'h0C0FFE, 24'h000777, 24'h00BEEF, 16'd5);
        bus.core_din_ready = 1'b1;
        wait_dones(5, "q_done");
`ifdef CHORUS_CHIRP_CTRL_TIMEOUT_EN
        check_val("wd_err_sticky", bus.status_err, 1'b1);
`else
        check_val("nowd_err_after", bus.status_err, 1'b0);
`endif

        // ctrl_enable dropped in LOAD: IDLE next cycle, count unchanged
        bus.core_din_ready = 1'b0;
        drive_update(24'h765432, 24'h000042, 24'h00A5A5);
        wait_load("r_reached_load");
        repeat (2) @(negedge clk);
        bus.ctrl_enable = 1'b0;
        @(negedge clk);
        check_val("drop_din_valid",   bus.core_din_valid,  1'b0);
        check_val("drop_core_enable", bus.core_enable,     1'b0);
        check_val("drop_running",     bus.status_running,  1'b0);
        check_val("drop_busy",        bus.cfg_busy,        1'b0);
        check_val("drop_load_cnt",    bus.status_load_cnt, 16'd5);
        check_val("drop_core_depth",  bus.core_depth,      24'h765432);
        push_exp(24'h765432, 24'h000042, 24'h00A5A5, 16'd6);
        bus.ctrl_enable    = 1'b1;
        bus.core_din_ready = 1'b1;
        wait_dones(6, "r_done");

        // Asynchronous reset in RUN
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_core_enable", bus.core_enable,     1'b0);
        check_val("arst_running",     bus.status_running,  1'b0);
        check_val("arst_load_cnt",    bus.status_load_cnt, 16'd0);
        check_val("arst_core_params", {bus.core_depth, bus.core_deriv, bus.core_offset}, 72'd0);
        check_val("arst_flags", {bus.cfg_done, bus.cfg_busy, bus.core_din_valid, bus.status_err}, 4'd0);

        // Update in IDLE during release is applied on the first FLUSH entry
        @(negedge clk);
        reset_n = 1'b1;
        push_exp(24'h00FACE, 24'h000009, 24'h0000FF, 16'd1);
        drive_update(24'h00FACE, 24'h000009, 24'h0000FF);
        wait_dones(7, "s_done");

        repeat (5) @(negedge clk);
        check_val("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
